// File: rtl/register_sync.sv
// register_sync: per-bit multi-flop synchronizer for quasi-static flags and
// status words entering the destination clock domain. Every stage powers up
// at (and resets to) reg_preset; the chain advances only while clk_en is high.
module register_sync #(
    parameter int                   reg_width     = 1,
    parameter logic [reg_width-1:0] reg_preset    = {reg_width{1'b0}},
    parameter int                   resync_stages = 2
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 clk_en,
    input  logic [reg_width-1:0] reg_i,
    output logic [reg_width-1:0] reg_o
);

    // Shorter chains give inadequate MTBF.
    // Longer chains only add latency for these slow-moving signals.
    if ((resync_stages < 2) || (resync_stages > 4)) begin : g_bad_stages
        $error("register_sync: resync_stages must be in the range 2..4");
    end

    // Each stage's output is exported here only to feed the next stage
    // (or reg_o from the last one); nothing else may tap into the chain.
    logic [reg_width-1:0] stage_q [resync_stages];

    genvar gi;
    for (gi = 0; gi < resync_stages; gi++) begin : g_stage
        logic [reg_width-1:0] stage_in;

        // Attributes keep the chain as discrete, adjacent flops: no retiming,
        // no merging of identical chains, no shift-register/RAM mapping.
        (* altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED", preserve, dont_merge *)
        logic [reg_width-1:0] stage_reg = reg_preset;

        // Stage 0 samples the asynchronous input; later stages sample their predecessor.
        if (gi == 0) begin : g_first
            assign stage_in = reg_i;
        end else begin : g_next
            assign stage_in = stage_q[gi-1];
        end

        // Shift one stage per enabled edge; reset to preset wins over the enable.
        always_ff @(posedge clk) begin
            if (!nrst) begin
                stage_reg <= reg_preset;
            end else if (clk_en) begin
                stage_reg <= stage_in;
            end
        end

        assign stage_q[gi] = stage_reg;
    end

    // Output is the last flop directly; no combinational path from reg_i.
    assign reg_o = stage_q[resync_stages-1];

endmodule

// File: tb/tb_register_sync.sv
// Scoreboard bench for register_sync: the stimulus process pushes the value
// expected on a chosen instance's reg_o after the next clock edge; a monitor
// pops and compares shortly after each rising edge.
module tb_register_sync;

    logic clk;

    // u0: 8 bits, preset A5, 2 stages (power-up without reset)
    logic       nrst0, en0;
    logic [7:0] ri0, ro0;
    // u1: 4 bits, preset 0, 2 stages (latency, hold, reset cases)
    logic       nrst1, en1;
    logic [3:0] ri1, ro1;
    // u2: 4 bits, preset 0, 3 stages (latency)
    logic       nrst2, en2;
    logic [3:0] ri2, ro2;
    // u3: 2 bits, preset 0, 2 stages (bit independence)
    logic       nrst3, en3;
    logic [1:0] ri3, ro3;

    register_sync #(.reg_width(8), .reg_preset(8'hA5), .resync_stages(2)) u0 (
        .clk(clk), .nrst(nrst0), .clk_en(en0), .reg_i(ri0), .reg_o(ro0));
    register_sync #(.reg_width(4), .reg_preset(4'h0), .resync_stages(2)) u1 (
        .clk(clk), .nrst(nrst1), .clk_en(en1), .reg_i(ri1), .reg_o(ro1));
    register_sync #(.reg_width(4), .reg_preset(4'h0), .resync_stages(3)) u2 (
        .clk(clk), .nrst(nrst2), .clk_en(en2), .reg_i(ri2), .reg_o(ro2));
    register_sync #(.reg_width(2), .reg_preset(2'b00), .resync_stages(2)) u3 (
        .clk(clk), .nrst(nrst3), .clk_en(en3), .reg_i(ri3), .reg_o(ro3));

    typedef struct {
        int         dut;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // First rising edge at t=10 so the power-up value can be checked first.
    initial begin
        clk = 1'b0;
        #10;
        forever begin
            clk = ~clk;
            #5;
        end
    end

    task automatic expect_o(input int d, input logic [7:0] v, input string n);
        exp_t e;
        e.dut  = d;
        e.exp  = v;
        e.name = n;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [7:0] actual_of(input int d);
        case (d)
            0:       return ro0;
            1:       return {4'h0, ro1};
            2:       return {4'h0, ro2};
            default: return {6'h0, ro3};
        endcase
    endfunction

    task automatic drain();
        exp_t       e;
        logic [7:0] act;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = actual_of(e.dut);
            checks++;
            if (act !== e.exp) begin
                errors++;
                $display("FAIL %s u%0d: reg_o=%h expected %h", e.name, e.dut, act, e.exp);
            end else begin
                $display("ok   %s u%0d: reg_o=%h", e.name, e.dut, act);
            end
        end
    endtask

    // Monitor: check power-up entries before any edge, then after every edge.
    initial begin
        #1;
        drain();
        forever begin
            @(posedge clk);
            #1;
            drain();
        end
    end

    // Stimulus
    initial begin
        logic [1:0] prev3;
        logic [1:0] cur3;

        nrst0 = 1'b1; en0 = 1'b1; ri0 = 8'h00;
        nrst1 = 1'b0; en1 = 1'b1; ri1 = 4'h0;
        nrst2 = 1'b0; en2 = 1'b1; ri2 = 4'h0;
        nrst3 = 1'b0; en3 = 1'b1; ri3 = 2'b00;

        // Power-up value visible with nrst tied high and no edge yet
        expect_o(0, 8'hA5, "pwrup_noedge");
        #2;
        expect_o(0, 8'hA5, "pwrup_edge1");
        tick();
        expect_o(0, 8'h00, "pwrup_edge2");
        expect_o(1, 8'h00, "u1_reset");
        expect_o(2, 8'h00, "u2_reset");
        tick();

        // Latency: fill with zeros, then step input to C before edge E
        nrst1 = 1'b1; nrst2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_o(1, 8'h00, "lat_fill");
            expect_o(2, 8'h00, "lat_fill");
            tick();
        end
        ri1 = 4'hC; ri2 = 4'hC;
        expect_o(1, 8'h00, "lat2_E");
        expect_o(2, 8'h00, "lat3_E");
        tick();
        expect_o(1, 8'h0C, "lat2_E1");
        expect_o(2, 8'h00, "lat3_E1");
        tick();
        expect_o(2, 8'h0C, "lat3_E2");
        tick();

        // Hold: enable low while input toggles 3/C
        en1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ri1 = (i % 2 == 0) ? 4'h3 : 4'hC;
            expect_o(1, 8'h0C, "hold");
            tick();
        end
        en1 = 1'b1; ri1 = 4'h3;
        expect_o(1, 8'h0C, "hold_rel1");
        tick();
        expect_o(1, 8'h03, "hold_rel2");
        tick();

        // Reset priority over clk_en
        ri1 = 4'hF;
        expect_o(1, 8'h03, "fillF_1");
        tick();
        expect_o(1, 8'h0F, "fillF_2");
        tick();
        nrst1 = 1'b0; en1 = 1'b0;
        expect_o(1, 8'h00, "rstpri");
        tick();
        nrst1 = 1'b1; en1 = 1'b1;
        expect_o(1, 8'h00, "rstpri_e1");
        tick();
        expect_o(1, 8'h0F, "rstpri_e2");
        tick();

        // Reset mid-flight discards the in-flight value
        ri1 = 4'h0;
        expect_o(1, 8'h0F, "mid_pre1");
        tick();
        expect_o(1, 8'h00, "mid_pre2");
        tick();
        ri1 = 4'h1;
        expect_o(1, 8'h00, "mid_E");
        tick();
        nrst1 = 1'b0;
        expect_o(1, 8'h00, "mid_rst1");
        tick();
        expect_o(1, 8'h00, "mid_rst2");
        tick();
        nrst1 = 1'b1;
        expect_o(1, 8'h00, "mid_rel1");
        tick();
        expect_o(1, 8'h01, "mid_rel2");
        tick();

        // Bit independence: bit1 constant 1, bit0 toggles every cycle
        nrst3 = 1'b1;
        prev3 = 2'b00;
        for (int i = 0; i < 8; i++) begin
            cur3 = {1'b1, i[0]};
            ri3 = cur3;
            expect_o(3, {6'h0, prev3}, "bits");
            prev3 = cur3;
            tick();
        end

        // Let the last entries drain, then make sure nothing was left unchecked
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Time limit
    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t, expected finish", $time);
        $fatal(1, "timeout");
    end

endmodule
